alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl_pkg.sv | 57 +++++
 rtl/instr_alu_decode.sv | 78 +++++++
 rtl/alu_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and types for the ALU issue controller.
// Opcode/funct values, ALU opcodes, FSM states, decode bundle.
package alu_issue_ctrl_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_MULI  = 6'h1D;

    localparam logic [5:0] F_SLL = 6'h01;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [5:0] F_MUL = 6'h2C;

    localparam logic [OW-1:0] ALU_NOP = 6'h00;
    localparam logic [OW-1:0] ALU_ADD = 6'h01;
    localparam logic [OW-1:0] ALU_SUB = 6'h02;
    localparam logic [OW-1:0] ALU_MUL = 6'h03;
    localparam logic [OW-1:0] ALU_SRL = 6'h04;
    localparam logic [OW-1:0] ALU_SLL = 6'h05;
    localparam logic [OW-1:0] ALU_AND = 6'h06;
    localparam logic [OW-1:0] ALU_OR  = 6'h07;
    localparam logic [OW-1:0] ALU_NOR = 6'h08;
    localparam logic [OW-1:0] ALU_SLT = 6'h09;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_EXEC,
        S_WB,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic          ok;
        logic [OW-1:0] oprn;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] dest;
        logic [DW-1:0] imm;
        logic          use_shamt;
        logic          use_imm;
    } dec_t;

endpackage

// File: rtl/instr_alu_decode.sv
// Combinational decode of a MIPS-format word into ALU issue fields.
// For shifts the imm field carries the zero-extended shamt.
module instr_alu_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [DW-1:0] instr,
    output dec_t          dec
);

    logic [5:0]    op;
    logic [5:0]    fn;
    logic [DW-1:0] sx;
    logic [DW-1:0] zx;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign sx = {{16{instr[15]}}, instr[15:0]};
    assign zx = {16'h0000, instr[15:0]};

    always_comb begin
        dec      = '0;
        dec.rs   = instr[25:21];
        dec.rt   = instr[20:16];
        dec.dest = instr[20:16];
        dec.ok   = 1'b1;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                dec.dest = instr[15:11];
                dec.imm  = {27'b0, instr[10:6]};
                unique case (1'b1)
                    (fn == F_ADD): dec.oprn = ALU_ADD;
                    (fn == F_SUB): dec.oprn = ALU_SUB;
                    (fn == F_MUL): dec.oprn = ALU_MUL;
                    (fn == F_AND): dec.oprn = ALU_AND;
                    (fn == F_OR):  dec.oprn = ALU_OR;
                    (fn == F_NOR): dec.oprn = ALU_NOR;
                    (fn == F_SLT): dec.oprn = ALU_SLT;
                    (fn == F_SRL): begin
                        dec.oprn      = ALU_SRL;
                        dec.use_shamt = 1'b1;
                    end
                    (fn == F_SLL): begin
                        dec.oprn      = ALU_SLL;
                        dec.use_shamt = 1'b1;
                    end
                    default: dec.ok = 1'b0;
                endcase
            end
            (op == OP_ADDI): begin
                dec.oprn    = ALU_ADD;
                dec.imm     = sx;
                dec.use_imm = 1'b1;
            end
            (op == OP_MULI): begin
                dec.oprn    = ALU_MUL;
                dec.imm     = sx;
                dec.use_imm = 1'b1;
            end
            (op == OP_SLTI): begin
                dec.oprn    = ALU_SLT;
                dec.imm     = sx;
                dec.use_imm = 1'b1;
            end
            (op == OP_ANDI): begin
                dec.oprn    = ALU_AND;
                dec.imm     = zx;
                dec.use_imm = 1'b1;
            end
            (op == OP_ORI): begin
                dec.oprn    = ALU_OR;
                dec.imm     = zx;
                dec.use_imm = 1'b1;
            end
            default: dec.ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Five-cycle issue controller: read RF, drive ALU, write back.
// All outputs are registered; ALU_OPRN is non-zero only in EXEC.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          INSTR_VALID,
    output logic          INSTR_READY,
    input  logic [DW-1:0] INSTR,
    output logic          RF_READ,
    output logic [AW-1:0] RF_ADDR_R1,
    output logic [AW-1:0] RF_ADDR_R2,
    input  logic [DW-1:0] RF_DATA_R1,
    input  logic [DW-1:0] RF_DATA_R2,
    output logic          RF_WRITE,
    output logic [AW-1:0] RF_ADDR_W,
    output logic [DW-1:0] RF_DATA_W,
    output logic [DW-1:0] ALU_OP1,
    output logic [DW-1:0] ALU_OP2,
    output logic [OW-1:0] ALU_OPRN,
    input  logic [DW-1:0] ALU_OUT,
    input  logic          ALU_ZERO,
    output logic          DONE,
    output logic          ERR,
    output logic          ZERO_FLAG
);

    state_t        state;
    dec_t          dec;
    logic [OW-1:0] oprn_q;
    logic [AW-1:0] dest_q;
    logic [DW-1:0] imm_q;
    logic          ush_q;
    logic          uimm_q;

    instr_alu_decode u_dec (
        .instr (INSTR),
        .dec   (dec)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            INSTR_READY <= 1'b1;
            RF_READ     <= 1'b0;
            RF_ADDR_R1  <= '0;
            RF_ADDR_R2  <= '0;
            RF_WRITE    <= 1'b0;
            RF_ADDR_W   <= '0;
            RF_DATA_W   <= '0;
            ALU_OP1     <= '0;
            ALU_OP2     <= '0;
            ALU_OPRN    <= ALU_NOP;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
            ZERO_FLAG   <= 1'b0;
            oprn_q      <= ALU_NOP;
            dest_q      <= '0;
            imm_q       <= '0;
            ush_q       <= 1'b0;
            uimm_q      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (INSTR_VALID && INSTR_READY) begin
                        INSTR_READY <= 1'b0;
                        if (dec.ok) begin
                            state      <= S_READ;
                            RF_READ    <= 1'b1;
                            RF_ADDR_R1 <= dec.rs;
                            RF_ADDR_R2 <= dec.rt;
                            oprn_q     <= dec.oprn;
                            dest_q     <= dec.dest;
                            imm_q      <= dec.imm;
                            ush_q      <= dec.use_shamt;
                            uimm_q     <= dec.use_imm;
                        end else begin
                            state <= S_FAULT;
                            ERR   <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    RF_READ <= 1'b0;
                    state   <= S_LATCH;
                end
                S_LATCH: begin
                    // shifts move the shifted value (rt) to OP1
                    ALU_OP1  <= ush_q ? RF_DATA_R2 : RF_DATA_R1;
                    ALU_OP2  <= (ush_q || uimm_q) ? imm_q
                                                  : RF_DATA_R2;
                    ALU_OPRN <= oprn_q;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    ZERO_FLAG <= ALU_ZERO;
                    ALU_OPRN  <= ALU_NOP;
                    RF_WRITE  <= (dest_q != '0);
                    RF_ADDR_W <= dest_q;
                    RF_DATA_W <= ALU_OUT;
                    DONE      <= 1'b1;
                    state     <= S_WB;
                end
                S_WB: begin
                    RF_WRITE    <= 1'b0;
                    DONE        <= 1'b0;
                    INSTR_READY <= 1'b1;
                    state       <= S_IDLE;
                end
                S_FAULT: begin
                    ERR         <= 1'b0;
                    INSTR_READY <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    INSTR_READY <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus random
// instructions checked against an instruction-level model.
module tb_alu_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] INSTR;
    logic        RF_READ;
    logic [4:0]  RF_ADDR_R1;
    logic [4:0]  RF_ADDR_R2;
    logic [31:0] RF_DATA_R1;
    logic [31:0] RF_DATA_R2;
    logic        RF_WRITE;
    logic [4:0]  RF_ADDR_W;
    logic [31:0] RF_DATA_W;
    logic [31:0] ALU_OP1;
    logic [31:0] ALU_OP2;
    logic [5:0]  ALU_OPRN;
    logic [31:0] ALU_OUT;
    logic        ALU_ZERO;
    logic        DONE;
    logic        ERR;
    logic        ZERO_FLAG;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [32];

    logic        o_rr  [1:5];
    logic        o_rw  [1:5];
    logic        o_dn  [1:5];
    logic        o_er  [1:5];
    logic        o_rdy [1:5];
    logic        o_z   [1:5];
    logic [5:0]  o_op  [1:5];
    logic [31:0] o_a   [1:5];
    logic [31:0] o_b   [1:5];
    logic [31:0] o_wd  [1:5];
    logic [4:0]  o_wa  [1:5];
    logic [4:0]  o_r1  [1:5];
    logic [4:0]  o_r2  [1:5];

    alu_issue_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .INSTR       (INSTR),
        .RF_READ     (RF_READ),
        .RF_ADDR_R1  (RF_ADDR_R1),
        .RF_ADDR_R2  (RF_ADDR_R2),
        .RF_DATA_R1  (RF_DATA_R1),
        .RF_DATA_R2  (RF_DATA_R2),
        .RF_WRITE    (RF_WRITE),
        .RF_ADDR_W   (RF_ADDR_W),
        .RF_DATA_W   (RF_DATA_W),
        .ALU_OP1     (ALU_OP1),
        .ALU_OP2     (ALU_OP2),
        .ALU_OPRN    (ALU_OPRN),
        .ALU_OUT     (ALU_OUT),
        .ALU_ZERO    (ALU_ZERO),
        .DONE        (DONE),
        .ERR         (ERR),
        .ZERO_FLAG   (ZERO_FLAG)
    );

    always #5 CLK = ~CLK;

    // register file: read data appears the cycle after the strobe
    always @(posedge CLK) begin
        if (RF_READ) begin
            RF_DATA_R1 <= (RF_ADDR_R1 == 0) ? 32'h0 : regs[RF_ADDR_R1];
            RF_DATA_R2 <= (RF_ADDR_R2 == 0) ? 32'h0 : regs[RF_ADDR_R2];
        end
    end

    always_comb begin
        ALU_OUT = 32'h0;
        case (ALU_OPRN)
            6'h01: ALU_OUT = ALU_OP1 + ALU_OP2;
            6'h02: ALU_OUT = ALU_OP1 - ALU_OP2;
            6'h03: ALU_OUT = ALU_OP1 * ALU_OP2;
            6'h04: ALU_OUT = ALU_OP1 >> ALU_OP2[4:0];
            6'h05: ALU_OUT = ALU_OP1 << ALU_OP2[4:0];
            6'h06: ALU_OUT = ALU_OP1 & ALU_OP2;
            6'h07: ALU_OUT = ALU_OP1 | ALU_OP2;
            6'h08: ALU_OUT = ~(ALU_OP1 | ALU_OP2);
            6'h09: ALU_OUT = {31'b0, $signed(ALU_OP1) < $signed(ALU_OP2)};
            default: ALU_OUT = 32'h0;
        endcase
    end
    assign ALU_ZERO = (ALU_OUT == 32'h0);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    function automatic void ref_exec(input logic [31:0] ins,
                                     output bit ok,
                                     output logic [4:0] dst,
                                     output logic [31:0] val);
        logic [31:0] s, t, se, ze;
        logic [4:0]  sh;
        s  = (ins[25:21] == 0) ? 32'h0 : regs[ins[25:21]];
        t  = (ins[20:16] == 0) ? 32'h0 : regs[ins[20:16]];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0, ins[15:0]};
        sh = ins[10:6];
        ok  = 1'b1;
        dst = ins[20:16];
        val = 32'h0;
        case (ins[31:26])
            6'h00: begin
                dst = ins[15:11];
                case (ins[5:0])
                    6'h20: val = s + t;
                    6'h22: val = s - t;
                    6'h2C: val = s * t;
                    6'h02: val = t >> sh;
                    6'h01: val = t << sh;
                    6'h24: val = s & t;
                    6'h25: val = s | t;
                    6'h27: val = ~(s | t);
                    6'h2A: val = ($signed(s) < $signed(t)) ? 1 : 0;
                    default: ok = 1'b0;
                endcase
            end
            6'h08: val = s + se;
            6'h1D: val = s * se;
            6'h0A: val = ($signed(s) < $signed(se)) ? 1 : 0;
            6'h0C: val = s & ze;
            6'h0D: val = s | ze;
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic start(input logic [31:0] ins, input bit hold);
        INSTR = ins;
        INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) begin
            INSTR_VALID = 1'b0;
            INSTR = $urandom;
        end
    endtask

    task automatic observe(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge CLK);
            o_rr[k]  = RF_READ;
            o_rw[k]  = RF_WRITE;
            o_dn[k]  = DONE;
            o_er[k]  = ERR;
            o_rdy[k] = INSTR_READY;
            o_z[k]   = ZERO_FLAG;
            o_op[k]  = ALU_OPRN;
            o_a[k]   = ALU_OP1;
            o_b[k]   = ALU_OP2;
            o_wd[k]  = RF_DATA_W;
            o_wa[k]  = RF_ADDR_W;
            o_r1[k]  = RF_ADDR_R1;
            o_r2[k]  = RF_ADDR_R2;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        INSTR_VALID = 1'b1;
        INSTR = 32'h00221820;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (INSTR_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 1", INSTR_READY);
        end
        checks++;
        if ({RF_READ, RF_WRITE, DONE, ERR, ZERO_FLAG} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b exp 00000",
                     {RF_READ, RF_WRITE, DONE, ERR, ZERO_FLAG});
        end
        checks++;
        if ({ALU_OP1, ALU_OP2, ALU_OPRN} !== 70'h0) begin
            errors++;
            $display("FAIL reset_alu: got %h %h %h exp 0",
                     ALU_OP1, ALU_OP2, ALU_OPRN);
        end
        checks++;
        if ({RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W} !== 47'h0) begin
            errors++;
            $display("FAIL reset_rf: got %h %h %h %h exp 0",
                     RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W);
        end
        RST = 1'b0;
        INSTR_VALID = 1'b0;
    endtask

    task automatic test_add();
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        start(32'h00221820, 1'b0);
        observe(5);
        checks++;
        if ({o_rr[1], o_r1[1], o_r2[1]} !== {1'b1, 5'd1, 5'd2}) begin
            errors++;
            $display("FAIL add_read: got %b %0d %0d exp 1 1 2",
                     o_rr[1], o_r1[1], o_r2[1]);
        end
        checks++;
        if ({o_a[3], o_b[3], o_op[3]} !== {32'd5, 32'd7, 6'h01}) begin
            errors++;
            $display("FAIL add_exec: got %h %h %h exp 5 7 01",
                     o_a[3], o_b[3], o_op[3]);
        end
        checks++;
        if ({o_op[2], o_op[4], o_rr[2], o_rw[3], o_dn[3]} !== 15'h0) begin
            errors++;
            $display("FAIL add_idle_cyc: got %h %h %b %b %b exp 0",
                     o_op[2], o_op[4], o_rr[2], o_rw[3], o_dn[3]);
        end
        checks++;
        if ({o_rw[4], o_wa[4], o_wd[4], o_dn[4]} !==
            {1'b1, 5'd3, 32'd12, 1'b1}) begin
            errors++;
            $display("FAIL add_wb: got %b %0d %h %b exp 1 3 c 1",
                     o_rw[4], o_wa[4], o_wd[4], o_dn[4]);
        end
        checks++;
        if ({o_z[4], o_rdy[4], o_rdy[5], o_dn[5]} !== 4'b0010) begin
            errors++;
            $display("FAIL add_tail: got %b%b%b%b exp 0010",
                     o_z[4], o_rdy[4], o_rdy[5], o_dn[5]);
        end
        regs[3] = 32'd12;
    endtask

    task automatic test_sub();
        start(32'h00212022, 1'b0);
        observe(5);
        checks++;
        if ({o_rw[4], o_wa[4], o_wd[4], o_z[4]} !==
            {1'b1, 5'd4, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL sub_wb: got %b %0d %h z%b exp 1 4 0 z1",
                     o_rw[4], o_wa[4], o_wd[4], o_z[4]);
        end
        regs[4] = 32'd0;
    endtask

    task automatic test_sll();
        start(32'h00022901, 1'b0);
        observe(5);
        checks++;
        if ({o_a[3], o_b[3], o_op[3]} !== {32'd7, 32'd4, 6'h05}) begin
            errors++;
            $display("FAIL sll_exec: got %h %h %h exp 7 4 05",
                     o_a[3], o_b[3], o_op[3]);
        end
        checks++;
        if ({o_rw[4], o_wa[4], o_wd[4]} !== {1'b1, 5'd5, 32'h70}) begin
            errors++;
            $display("FAIL sll_wb: got %b %0d %h exp 1 5 70",
                     o_rw[4], o_wa[4], o_wd[4]);
        end
        regs[5] = 32'h70;
    endtask

    task automatic test_imm();
        start(32'h2026FFFF, 1'b0);
        observe(5);
        checks++;
        if ({o_b[3], o_wa[4], o_wd[4]} !== {32'hFFFFFFFF, 5'd6, 32'd4})
        begin
            errors++;
            $display("FAIL addi: got %h %0d %h exp ffffffff 6 4",
                     o_b[3], o_wa[4], o_wd[4]);
        end
        regs[6] = 32'd4;
        start(32'h34078000, 1'b0);
        observe(5);
        checks++;
        if ({o_b[3], o_wa[4], o_wd[4], o_rw[4]} !==
            {32'h8000, 5'd7, 32'h8000, 1'b1}) begin
            errors++;
            $display("FAIL ori: got %h %0d %h %b exp 8000 7 8000 1",
                     o_b[3], o_wa[4], o_wd[4], o_rw[4]);
        end
        regs[7] = 32'h8000;
    endtask

    task automatic test_fault();
        logic zb;
        zb = ZERO_FLAG;
        start(32'hFC000000, 1'b0);
        observe(2);
        checks++;
        if ({o_er[1], o_er[2], o_rdy[1], o_rdy[2]} !== 4'b1001) begin
            errors++;
            $display("FAIL fault_err: got %b%b%b%b exp 1001",
                     o_er[1], o_er[2], o_rdy[1], o_rdy[2]);
        end
        checks++;
        if ({o_rr[1], o_rr[2], o_rw[1], o_rw[2], o_dn[1], o_dn[2],
             o_op[1], o_op[2]} !== 18'h0) begin
            errors++;
            $display("FAIL fault_quiet: got %b%b%b%b%b%b %h %h exp 0",
                     o_rr[1], o_rr[2], o_rw[1], o_rw[2],
                     o_dn[1], o_dn[2], o_op[1], o_op[2]);
        end
        checks++;
        if (o_z[2] !== zb) begin
            errors++;
            $display("FAIL fault_zflag: got %b exp %b", o_z[2], zb);
        end
    endtask

    task automatic test_rd0();
        start(32'h00220020, 1'b0);
        observe(5);
        checks++;
        if ({o_dn[4], o_rw[4], o_z[4]} !== 3'b100) begin
            errors++;
            $display("FAIL rd0: got dn%b rw%b z%b exp dn1 rw0 z0",
                     o_dn[4], o_rw[4], o_z[4]);
        end
    endtask

    task automatic test_rst_abort();
        regs[3] = 32'd0;
        start(32'h00221820, 1'b1);
        observe(3);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({INSTR_READY, RF_WRITE, DONE, ERR, ALU_OPRN} !==
            {4'b1000, 6'h0}) begin
            errors++;
            $display("FAIL abort_state: got %b%b%b%b %h exp 1000 00",
                     INSTR_READY, RF_WRITE, DONE, ERR, ALU_OPRN);
        end
        RST = 1'b0;
        @(posedge CLK);
        #1;
        INSTR_VALID = 1'b0;
        observe(5);
        checks++;
        if ({o_rr[1], o_dn[3], o_dn[4], o_rw[4], o_wd[4], o_rdy[5]} !==
            {4'b1011, 32'd12, 1'b1}) begin
            errors++;
            $display("FAIL abort_next: got %b%b%b%b %h %b exp 1011 c 1",
                     o_rr[1], o_dn[3], o_dn[4], o_rw[4], o_wd[4],
                     o_rdy[5]);
        end
        regs[3] = 32'd12;
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fl [9] = '{6'h20, 6'h22, 6'h2C, 6'h02, 6'h01,
                                6'h24, 6'h25, 6'h27, 6'h2A};
        logic [5:0]  il [5] = '{6'h08, 6'h1D, 6'h0A, 6'h0C, 6'h0D};
        logic [31:0] ins, val;
        logic [4:0]  dst;
        bit          ok;
        int          sel;
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h0;
        regs[9] = 32'h0;
        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            sel = $urandom_range(0, 9);
            if (sel <= 3) ins = {6'h00, ins[25:6], fl[$urandom_range(0, 8)]};
            else if (sel == 4) ins[31:26] = 6'h00;
            else if (sel <= 8) ins[31:26] = il[$urandom_range(0, 4)];
            if (n % 7 == 0) ins[25:21] = 5'd9;
            ref_exec(ins, ok, dst, val);
            start(ins, 1'b0);
            if (ok) begin
                observe(5);
                checks++;
                if ({o_rr[1], o_r1[1], o_r2[1]} !==
                    {1'b1, ins[25:21], ins[20:16]}) begin
                    errors++;
                    $display("FAIL rnd_read %h: got %b %0d %0d", ins,
                             o_rr[1], o_r1[1], o_r2[1]);
                end
                checks++;
                if ({o_dn[3], o_dn[4], o_rw[4], o_er[1], o_rdy[5]} !==
                    {2'b01, dst != 0, 2'b01}) begin
                    errors++;
                    $display("FAIL rnd_ctl %h: got %b%b%b%b%b exp 01%b01",
                             ins, o_dn[3], o_dn[4], o_rw[4], o_er[1],
                             o_rdy[5], dst != 0);
                end
                checks++;
                if (dst != 0 && {o_wa[4], o_wd[4]} !== {dst, val}) begin
                    errors++;
                    $display("FAIL rnd_wb %h: got %0d %h exp %0d %h",
                             ins, o_wa[4], o_wd[4], dst, val);
                end
                checks++;
                if (o_z[4] !== (val == 0)) begin
                    errors++;
                    $display("FAIL rnd_zflag %h: got %b exp %b",
                             ins, o_z[4], val == 0);
                end
                if (dst != 0) regs[dst] = val;
            end else begin
                observe(2);
                checks++;
                if ({o_er[1], o_er[2], o_rr[1], o_dn[1], o_rdy[2]} !==
                    5'b10001) begin
                    errors++;
                    $display("FAIL rnd_fault %h: got %b%b%b%b%b exp 10001",
                             ins, o_er[1], o_er[2], o_rr[1], o_dn[1],
                             o_rdy[2]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        RST = 1'b1;
        INSTR_VALID = 1'b0;
        INSTR = 32'h0;
        @(negedge CLK);
        test_reset();
        test_add();
        test_sub();
        test_sll();
        test_imm();
        test_fault();
        test_rd0();
        test_rst_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
